xm_wb_ram: RTL and testbench
============================

Name: xm_wb_ram

Overview:
Wishbone-style single-port RAM slave that sits directly downstream of the CPU's bus master port. It consumes cyc/stb/we/sel/adr/dat and returns ack/err/dat. Programmable wait states let the bench and system model slow memory. Byte-lane writes support the CPU's byte operations.

Parameters:
WORD, 16, data width in bits; must be 16 because sel is 2 bits.
ADR_W, 15, word-address width; matches the CPU's WORD-(WORD/8)+1 address bus.
DEPTH_LOG2, 10, log2 of RAM depth in words; the RAM has 1024 words by default.
BASE, 15'h0000, word address of RAM word 0.
WAIT, 1, number of wait-state cycles inserted before ack/err; legal range 0..15.

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
arst_i  in  1  reset; asynchronous, active-low.
cyc_i  in  1  bus cycle valid.
stb_i  in  1  transfer strobe.
we_i  in  1  1 = write, 0 = read.
sel_i  in  2  byte lanes: bit1 = dat[15:8], bit0 = dat[7:0].
adr_i  in  ADR_W  word address.
dat_i  in  WORD  write data.
ack_o  out  1  transfer complete; one-cycle pulse.
err_o  out  1  address outside the RAM window; one-cycle pulse, never coincident with ack_o.
dat_o  out  WORD  read data; registered.

Behaviour:
- Reset (arst_i=0, asynchronous): FSM goes to IDLE; wait counter = 0; ack_o = 0; err_o = 0; dat_o = 0; latched request registers = 0. RAM contents are not reset.
- Deassertion of reset takes effect at the next clock edge. Reset asserted mid-transfer aborts the transfer: no write occurs and no ack is issued.
- FSM states are IDLE, WAIT and RESP.
- IDLE: on an edge with cyc_i & stb_i = 1:
  - Latch adr, we, sel, dat.
  - Compute hit = (adr_i - BASE) < 2^DEPTH_LOG2, using unsigned ADR_W-bit wrap-around.
  - Load counter = WAIT.
  - Go to WAIT if WAIT > 0, otherwise go directly to RESP.
- WAIT: the counter decrements each edge. When the counter = 1, go to RESP. If cyc_i = 0 on any WAIT edge, abort: go to IDLE with no write and no ack/err. stb_i is ignored in WAIT.
- Transition into RESP, on the same edge:
  - Write hit: RAM[adr-BASE] is updated per sel lanes only; sel=00 writes nothing but still acks.
  - Read hit: dat_o <= RAM[adr-BASE], the full word regardless of sel.
  - Miss: no RAM access; dat_o holds its value.
  - ack_o <= hit and err_o <= !hit, registered.
- RESP: ack_o/err_o are high for exactly this cycle. Next edge: ack_o = err_o = 0 and the FSM goes to IDLE. cyc_i/stb_i are not sampled in RESP.
- Latency: a request accepted at edge k gives ack/err high during cycle k+1+WAIT. The minimum request-to-request spacing is WAIT+2 cycles. If the master holds stb_i high after ack, the next IDLE edge starts a new transfer; the master must drop stb on ack to avoid a repeat.
- dat_o holds the last read value until the next read hit, and is unaffected by writes.
- cyc_i=1 with stb_i=0 in IDLE: remain in IDLE.
- Read-after-write to the same address returns the new data. Ordering is guaranteed by the serial FSM.

Test Plan:
- Reset check: hold arst_i=0 for 3 cycles, then release. ack_o=0, err_o=0, dat_o=16'h0000, and the FSM is in IDLE.
- Full write then read, WAIT=1: write adr=15'h0004, dat=16'hBEEF, sel=11. ack_o pulses exactly 2 cycles after acceptance, for 1 cycle. Reading 15'h0004 then returns dat_o=16'hBEEF with the same latency.
- Byte lanes: after the BEEF write, write dat=16'h1234 with sel=01, then sel=00 with 16'hFFFF. Read gives 16'hBE34, and both writes ack.
- Out of range, BASE=0, DEPTH_LOG2=10: write adr=15'h0400. err_o pulses 1 cycle and ack_o stays 0. Reading 15'h0000 shows its contents unchanged. A read miss leaves dat_o unchanged.
- Abort, WAIT=3: start a write to 15'h0010 with 16'hAAAA and drop cyc_i after 1 wait cycle. No ack/err occurs and a later read of 15'h0010 returns the old value. Repeat with arst_i pulsed low mid-WAIT: same result.
- WAIT=0 back-to-back: 4 reads with stb held, re-asserted after each ack. Each ack arrives 1 cycle after acceptance at 2-cycle spacing, and no transfer is lost or duplicated (ack count = 4).

Source files
------------

// File: rtl/xm_wb_ram.sv
// Wishbone-style single-port RAM slave with programmable wait states,
// byte-lane writes and an error response for addresses outside the window.
module xm_wb_ram #(
  parameter int               WORD       = 16,
  parameter int               ADR_W      = 15,
  parameter int               DEPTH_LOG2 = 10,
  parameter logic [ADR_W-1:0] BASE       = '0,
  parameter int               WAIT       = 1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [1:0]       sel_i,
  input  logic [ADR_W-1:0] adr_i,
  input  logic [WORD-1:0]  dat_i,
  output logic             ack_o,
  output logic             err_o,
  output logic [WORD-1:0]  dat_o
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             we_q, we_d;
  logic [1:0]       sel_q, sel_d;
  logic [WORD-1:0]  dat_q, dat_d;
  logic             hit_q, hit_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [WORD-1:0]  rdat_q, rdat_d;

  logic [WORD-1:0]       mem [DEPTH];
  logic [ADR_W-1:0]      in_off_s;
  logic                  in_hit_s;
  logic [ADR_W-1:0]      req_adr_s;
  logic [ADR_W-1:0]      req_off_s;
  logic                  req_we_s;
  logic [1:0]            req_sel_s;
  logic [WORD-1:0]       req_dat_s;
  logic                  req_hit_s;
  logic [DEPTH_LOG2-1:0] req_idx_s;
  logic                  go_resp_s;
  logic                  ram_we_s;

  // Window check uses wrap-around subtraction, so a BASE near the top of
  // the address space maps its window across zero.
  assign in_off_s = adr_i - BASE;
  assign in_hit_s = (in_off_s[ADR_W-1:DEPTH_LOG2] == '0);

  // Next-state, request latching and response generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    hit_d     = hit_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdat_d    = rdat_q;
    go_resp_s = 1'b0;
    req_adr_s = adr_q;
    req_we_s  = we_q;
    req_sel_s = sel_q;
    req_dat_s = dat_q;
    req_hit_s = hit_q;

    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          adr_d     = adr_i;
          we_d      = we_i;
          sel_d     = sel_i;
          dat_d     = dat_i;
          hit_d     = in_hit_s;
          cnt_d     = WAIT_C;
          req_adr_s = adr_i;
          req_we_s  = we_i;
          req_sel_s = sel_i;
          req_dat_s = dat_i;
          req_hit_s = in_hit_s;
          if (WAIT_C != 4'd0) begin
            state_d = ST_WAIT;
          end else begin
            state_d   = ST_RESP;
            go_resp_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d   = ST_RESP;
          cnt_d     = 4'd0;
          go_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    req_off_s = req_adr_s - BASE;
    req_idx_s = req_off_s[DEPTH_LOG2-1:0];

    if (go_resp_s) begin
      ack_d = req_hit_s;
      err_d = !req_hit_s;
      if (req_hit_s && !req_we_s) begin
        rdat_d = mem[req_idx_s];
      end else begin
        rdat_d = rdat_q;
      end
    end else begin
      ack_d = 1'b0;
      err_d = 1'b0;
    end
  end

  // Gated by reset so a request pending while reset is low never lands.
  assign ram_we_s = go_resp_s && req_we_s && req_hit_s && arst_i;

  // Byte-lane RAM write port; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (ram_we_s) begin
      for (int b = 0; b < WORD / 8; b++) begin
        if (req_sel_s[b]) begin
          mem[req_idx_s][b*8 +: 8] <= req_dat_s[b*8 +: 8];
        end
      end
    end
  end

  // Control and response registers
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      dat_q   <= '0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      hit_q   <= hit_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = rdat_q;

endmodule

// File: tb/tb_xm_wb_ram.sv
// Bench for xm_wb_ram: three instances (WAIT=1, WAIT=3 with a wrapping BASE,
// WAIT=0) checked against a word-array reference model.
module tb_xm_wb_ram;

  localparam int               WT    [3] = '{1, 3, 0};
  localparam logic [14:0]      BASEV [3] = '{15'h0000, 15'h7F00, 15'h0000};

  logic        clk = 1'b0;
  logic [2:0]  arst, cyc, stb, we, ack, err;
  logic [1:0]  sel  [3];
  logic [14:0] adr  [3];
  logic [15:0] dat  [3];
  logic [15:0] dout [3];

  logic [15:0] mem  [3][1024];
  logic [15:0] dexp [3];
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [14:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic        hit;
    logic [15:0] dexp;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  xm_wb_ram #(.WAIT(1), .BASE(15'h0000)) u0 (
    .clk_i(clk), .arst_i(arst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .sel_i(sel[0]), .adr_i(adr[0]), .dat_i(dat[0]),
    .ack_o(ack[0]), .err_o(err[0]), .dat_o(dout[0]));
  xm_wb_ram #(.WAIT(3), .BASE(15'h7F00)) u1 (
    .clk_i(clk), .arst_i(arst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .sel_i(sel[1]), .adr_i(adr[1]), .dat_i(dat[1]),
    .ack_o(ack[1]), .err_o(err[1]), .dat_o(dout[1]));
  xm_wb_ram #(.WAIT(0), .BASE(15'h0000)) u2 (
    .clk_i(clk), .arst_i(arst[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
    .sel_i(sel[2]), .adr_i(adr[2]), .dat_i(dat[2]),
    .ack_o(ack[2]), .err_o(err[2]), .dat_o(dout[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic mhit(input int i, input logic [14:0] a);
    logic [14:0] off;
    off = a - BASEV[i];
    return off < 15'd1024;
  endfunction

  task automatic model_apply(input int i, input logic w, input logic [14:0] a,
                             input logic [1:0] s, input logic [15:0] d);
    logic [14:0] off;
    off = a - BASEV[i];
    if (off < 15'd1024) begin
      if (w) begin
        if (s[0]) mem[i][off[9:0]][7:0]  = d[7:0];
        if (s[1]) mem[i][off[9:0]][15:8] = d[15:8];
      end else begin
        dexp[i] = mem[i][off[9:0]];
      end
    end
  endtask

  // One complete transfer: latency, response kind, data and pulse width.
  task automatic xfer(input int i, input logic w, input logic [14:0] a, input logic [1:0] s,
                      input logic [15:0] d, input logic eh, input logic [15:0] ed, input string nm);
    int lat;
    @(negedge clk);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; sel[i] = s; dat[i] = d;
    @(posedge clk);
    @(negedge clk);
    stb[i] = 1'b0;
    lat = 1;
    while (ack[i] === 1'b0 && err[i] === 1'b0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, WT[i] + 1);
    chk({nm, " ack"}, {31'd0, ack[i]}, {31'd0, eh});
    chk({nm, " err"}, {31'd0, err[i]}, {31'd0, !eh});
    chk({nm, " dat_o"}, {16'd0, dout[i]}, {16'd0, ed});
    @(negedge clk);
    chk({nm, " pulse"}, {30'd0, ack[i], err[i]}, 32'd0);
    cyc[i] = 1'b0;
  endtask

  task automatic mtxn(input int i, input logic w, input logic [14:0] a,
                      input logic [1:0] s, input logic [15:0] d, input string nm);
    logic h;
    h = mhit(i, a);
    model_apply(i, w, a, s, d);
    xfer(i, w, a, s, d, h, dexp[i], nm);
  endtask

  initial begin
    int acks, last;
    logic [14:0] ra;
    for (int i = 0; i < 3; i++) begin
      arst[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      sel[i] = 2'b00; adr[i] = 15'h0000; dat[i] = 16'h0000; dexp[i] = 16'h0000;
    end

    // Reset
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ack%0d", i), {31'd0, ack[i]}, 32'd0);
      chk($sformatf("reset err%0d", i), {31'd0, err[i]}, 32'd0);
      chk($sformatf("reset dat%0d", i), {16'd0, dout[i]}, 32'd0);
    end
    arst = 3'b111;
    @(negedge clk);
    chk("idle after reset", {29'd0, ack, err[2:0] & 3'b000}, 32'd0);

    // Prefill every word so all later reads have known contents
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 1024; k++)
        mtxn(i, 1'b1, BASEV[i] + 15'(k), 2'b11, 16'(k * 40503 + i * 7), "prefill");

    // Directed vectors on the WAIT=1 instance
    tbl[0]  = '{1'b1, 15'h0004, 2'b11, 16'hBEEF, 1'b1, 16'h0000};
    tbl[1]  = '{1'b0, 15'h0004, 2'b11, 16'h0000, 1'b1, 16'hBEEF};
    tbl[2]  = '{1'b1, 15'h0004, 2'b01, 16'h1234, 1'b1, 16'hBEEF};
    tbl[3]  = '{1'b1, 15'h0004, 2'b00, 16'hFFFF, 1'b1, 16'hBEEF};
    tbl[4]  = '{1'b0, 15'h0004, 2'b11, 16'h0000, 1'b1, 16'hBE34};
    tbl[5]  = '{1'b1, 15'h0000, 2'b11, 16'hC0DE, 1'b1, 16'hBE34};
    tbl[6]  = '{1'b1, 15'h0400, 2'b11, 16'hDEAD, 1'b0, 16'hBE34};
    tbl[7]  = '{1'b0, 15'h0000, 2'b11, 16'h0000, 1'b1, 16'hC0DE};
    tbl[8]  = '{1'b0, 15'h7FFF, 2'b11, 16'h0000, 1'b0, 16'hC0DE};
    tbl[9]  = '{1'b1, 15'h0004, 2'b10, 16'hAB77, 1'b1, 16'hC0DE};
    tbl[10] = '{1'b0, 15'h0004, 2'b11, 16'h0000, 1'b1, 16'hAB34};
    tbl[11] = '{1'b1, 15'h03FF, 2'b11, 16'h1357, 1'b1, 16'hAB34};
    tbl[12] = '{1'b0, 15'h03FF, 2'b01, 16'h0000, 1'b1, 16'h1357};
    for (int v = 0; v < 13; v++) begin
      xfer(0, tbl[v].we, tbl[v].adr, tbl[v].sel, tbl[v].dat, tbl[v].hit, tbl[v].dexp,
           $sformatf("vec%0d", v));
      model_apply(0, tbl[v].we, tbl[v].adr, tbl[v].sel, tbl[v].dat);
    end

    // Aborts on the WAIT=3 instance: cyc dropped, then reset pulsed, mid-WAIT
    mtxn(1, 1'b1, 15'h0010, 2'b11, 16'h5555, "abort setup");
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 15'h0010;
      sel[1] = 2'b11; dat[1] = 16'hAAAA;
      @(posedge clk);
      @(negedge clk);
      stb[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (r == 1) begin
        arst[1] = 1'b0;
        dexp[1] = 16'h0000;
      end else begin
        cyc[1] = 1'b0;
      end
      acks = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        arst[1] = 1'b1;
        cyc[1]  = 1'b0;
        if (ack[1] !== 1'b0 || err[1] !== 1'b0) acks++;
      end
      chk($sformatf("abort%0d no response", r), acks, 0);
      chk($sformatf("abort%0d dat_o", r), {16'd0, dout[1]}, {16'd0, dexp[1]});
      mtxn(1, 1'b0, 15'h0010, 2'b11, 16'h0000, $sformatf("abort%0d readback", r));
    end
    mtxn(1, 1'b0, 15'h7F00, 2'b11, 16'h0000, "wrap low edge");
    mtxn(1, 1'b0, 15'h7EFF, 2'b11, 16'h0000, "wrap below");
    mtxn(1, 1'b0, 15'h02FF, 2'b11, 16'h0000, "wrap high edge");
    mtxn(1, 1'b1, 15'h0300, 2'b11, 16'h9999, "wrap above");

    // WAIT=0 back-to-back reads with stb held
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 15'h0000; sel[2] = 2'b11;
    acks = 0; last = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ack[2] === 1'b1) begin
        chk($sformatf("b2b spacing%0d", acks), c - last, (acks == 0) ? 1 : 2);
        chk($sformatf("b2b data%0d", acks), {16'd0, dout[2]}, {16'd0, mem[2][acks % 1024]});
        acks++;
        last = c;
        if (acks == 4) begin
          cyc[2] = 1'b0; stb[2] = 1'b0;
        end else begin
          adr[2] = 15'(acks);
        end
      end
    end
    chk("b2b ack count", acks, 4);
    dexp[2] = mem[2][3];

    // Randomised traffic against the model
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < 120; t++) begin
        if ($urandom_range(0, 1) == 0) ra = BASEV[i] + 15'($urandom_range(0, 1023));
        else ra = 15'($urandom);
        mtxn(i, 1'($urandom), ra, 2'($urandom), 16'($urandom), $sformatf("rand%0d.%0d", i, t));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
